// File: rtl/barrel_shifter_seq.sv
// ============================================================================
// barrel_shifter_seq : multi-cycle SLL/SRL/SRA/ROR unit, K log stages per clock
// Revision 1.0
// ============================================================================
`default_nettype none

module barrel_shifter_seq #(
  parameter int N = 5,
  parameter int K = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   A,
  input  logic [N-1:0]      shamt,
  input  logic [1:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   Y
);

  localparam int W  = 2**N;
  localparam int C  = (N + K - 1) / K;
  localparam int SW = $clog2(C + 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(C - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    work;
  logic [W-1:0]    work_nxt;
  logic [N-1:0]    amt;
  logic [1:0]      opr;
  logic [SW-1:0]   stage;

  // Log stage s belongs to group s/K; only the current group's stages act.
  always_comb begin
    work_nxt = work;
    for (int s = 0; s < N; s++) begin
      if (amt[s] && ((s / K) == int'(stage))) begin
        case (opr)
          2'b00:   work_nxt = work_nxt << (2**s);
          2'b01:   work_nxt = work_nxt >> (2**s);
          2'b10:   work_nxt = $unsigned($signed(work_nxt) >>> (2**s));
          default: work_nxt = (work_nxt >> (2**s)) | (work_nxt << (W - 2**s));
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      work      <= '0;
      amt       <= '0;
      opr       <= '0;
      stage     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= A;
            amt      <= shamt;
            opr      <= op;
            stage    <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
          end
        end
        SHIFT: begin
          work  <= work_nxt;
          stage <= stage + SW'(1);
          if (stage == LAST_STAGE) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign Y = work;

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_seq.sv
// ============================================================================
// tb_barrel_shifter_seq : directed and exhaustive checks, N=3 with K=1,2,3
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_barrel_shifter_seq;

  logic       clock;
  logic       reset;
  logic       iv   [3];
  logic       ir   [3];
  logic       ov   [3];
  logic       ordy [3];
  logic [7:0] a    [3];
  logic [7:0] y    [3];
  logic [2:0] sh   [3];
  logic [1:0] op   [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cfg_c [3] = '{3, 2, 1};

  barrel_shifter_seq #(.N(3), .K(1)) u_k1 (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .A(a[0]),
    .shamt(sh[0]), .op(op[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .Y(y[0]));
  barrel_shifter_seq #(.N(3), .K(2)) u_k2 (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .A(a[1]),
    .shamt(sh[1]), .op(op[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .Y(y[1]));
  barrel_shifter_seq #(.N(3), .K(3)) u_k3 (
    .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .A(a[2]),
    .shamt(sh[2]), .op(op[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .Y(y[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] model(input logic [7:0] av, input logic [2:0] s, input logic [1:0] o);
    logic [15:0] r;
    r = {av, av} >> s;
    case (o)
      2'b00:   model = av << s;
      2'b01:   model = av >> s;
      2'b10:   model = $unsigned($signed(av) >>> s);
      default: model = r[7:0];
    endcase
  endfunction

  // Drives one request and drains it; called at posedge+1 with the unit idle.
  task automatic do_txn(input int d, input logic [7:0] av, input logic [2:0] sv, input logic [1:0] ov_op,
                        input int stall, output logic [7:0] res, output int lat,
                        output int busy_bad, output logic rdy_after);
    busy_bad = 0;
    a[d] = av; sh[d] = sv; op[d] = ov_op; iv[d] = 1'b1;
    @(posedge clock); #1;
    iv[d] = 1'b0;
    lat = 0;
    while (ov[d] !== 1'b1 && lat < 20) begin
      if (ir[d] !== 1'b0) busy_bad++;
      @(posedge clock); #1;
      lat++;
    end
    if (ov[d] !== 1'b1) lat = -1;
    for (int i = 0; i < stall; i++) begin
      if (ir[d] !== 1'b0) busy_bad++;
      @(posedge clock); #1;
    end
    res = y[d];
    ordy[d] = 1'b1;
    @(posedge clock); #1;
    ordy[d] = 1'b0;
    rdy_after = ir[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || y[d] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b Y=%h, required 1 0 00", d, ir[d], ov[d], y[d]);
      end
    end
  endtask

  task automatic test_srl();
    logic [7:0] res; int lat; int bad; logic rdy;
    do_txn(0, 8'hA0, 3'd5, 2'b01, 0, res, lat, bad, rdy);
    n_checks++;
    if (res !== 8'h05) begin n_fail++; $display("FAIL srl_value: Y=%h, required 05", res); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL srl_latency: %0d cycles, required 3", lat); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL srl_busy_ready: in_ready high %0d times, required 0", bad); end
    n_checks++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL srl_ready_after: in_ready=%b, required 1", rdy); end
  endtask

  task automatic test_sra();
    logic [7:0] res; int lat; int bad; logic rdy;
    do_txn(0, 8'hA0, 3'd5, 2'b10, 0, res, lat, bad, rdy);
    n_checks++;
    if (res !== 8'hFD) begin n_fail++; $display("FAIL sra_value: Y=%h, required FD", res); end
  endtask

  task automatic test_sll_ror();
    logic [7:0] res; int lat; int bad; logic rdy;
    do_txn(0, 8'h28, 3'd3, 2'b00, 1, res, lat, bad, rdy);
    n_checks++;
    if (res !== 8'h40) begin n_fail++; $display("FAIL sll_value: Y=%h, required 40", res); end
    do_txn(0, 8'h81, 3'd1, 2'b11, 0, res, lat, bad, rdy);
    n_checks++;
    if (res !== 8'hC0) begin n_fail++; $display("FAIL ror_value: Y=%h, required C0", res); end
    do_txn(0, 8'hB5, 3'd7, 2'b11, 0, res, lat, bad, rdy);
    n_checks++;
    if (res !== 8'h6B) begin n_fail++; $display("FAIL ror_max_value: Y=%h, required 6B", res); end
    do_txn(0, 8'h01, 3'd7, 2'b00, 0, res, lat, bad, rdy);
    n_checks++;
    if (res !== 8'h80) begin n_fail++; $display("FAIL sll_max_value: Y=%h, required 80", res); end
  endtask

  task automatic test_zero_shamt();
    logic [7:0] res; int lat; int bad; logic rdy;
    for (int o = 0; o < 4; o++) begin
      do_txn(0, 8'h9A, 3'd0, 2'(o), 0, res, lat, bad, rdy);
      n_checks++;
      if (res !== 8'h9A || lat !== 3) begin
        n_fail++;
        $display("FAIL zero_shamt op%0d: Y=%h lat=%0d, required 9A lat=3", o, res, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int lat;
    a[0] = 8'h3C; sh[0] = 3'd2; op[0] = 2'b01; iv[0] = 1'b1;
    @(posedge clock); #1;
    iv[0] = 1'b0;
    a[0] = 8'hFF;
    lat = 0;
    while (ov[0] !== 1'b1 && lat < 20) begin @(posedge clock); #1; lat++; end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL bp_latency: %0d cycles, required 3", lat); end
    held = y[0];
    n_checks++;
    if (held !== 8'h0F) begin n_fail++; $display("FAIL bp_value: Y=%h, required 0F", held); end
    for (int i = 0; i < 4; i++) begin
      iv[0] = (i == 1); sh[0] = 3'd1; op[0] = 2'b00;
      @(posedge clock); #1;
      iv[0] = 1'b0;
      n_checks++;
      if (y[0] !== 8'h0F || ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cycle%0d: Y=%h in_ready=%b out_valid=%b, required 0F 0 1", i, y[0], ir[0], ov[0]);
      end
    end
    ordy[0] = 1'b1;
    @(posedge clock); #1;
    ordy[0] = 1'b0;
    n_checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", ir[0], ov[0]);
    end
    for (int i = 0; i < 5; i++) begin @(posedge clock); #1; end
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_ignored_pulse: out_valid=%b in_ready=%b, required 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res; int lat; int bad; logic rdy; int seen;
    a[0] = 8'hA0; sh[0] = 3'd5; op[0] = 2'b10; iv[0] = 1'b1;
    @(posedge clock); #1;
    iv[0] = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ov[0] !== 1'b0 || y[0] !== 8'h00 || ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_immediate: out_valid=%b Y=%h in_ready=%b, required 0 00 1", ov[0], y[0], ir[0]);
    end
    #2;
    reset = 1'b0;
    @(posedge clock); #1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (ov[0] !== 1'b0) seen++;
      @(posedge clock); #1;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_result: out_valid seen %0d times, required 0", seen); end
    do_txn(0, 8'h28, 3'd3, 2'b00, 0, res, lat, bad, rdy);
    n_checks++;
    if (res !== 8'h40 || lat !== 3) begin
      n_fail++; $display("FAIL reset_mid_next: Y=%h lat=%0d, required 40 lat=3", res, lat);
    end
  endtask

  task automatic test_exhaustive(input int d);
    logic [7:0] res; logic [7:0] exp_v; int lat; int bad; logic rdy; int stall;
    for (int av = 0; av < 256; av++) begin
      for (int sv = 0; sv < 8; sv++) begin
        for (int o = 0; o < 4; o++) begin
          stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
          do_txn(d, 8'(av), 3'(sv), 2'(o), stall, res, lat, bad, rdy);
          exp_v = model(8'(av), 3'(sv), 2'(o));
          n_checks++;
          if (res !== exp_v || lat !== cfg_c[d]) begin
            n_fail++;
            $display("FAIL exhaustive dut%0d A=%h sh=%0d op=%0d: Y=%h lat=%0d, required %h lat=%0d",
                     d, av, sv, o, res, lat, exp_v, cfg_c[d]);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; a[d] = '0; sh[d] = '0; op[d] = '0;
    end
    #1;
    test_reset();
    @(posedge clock); #1;
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_srl();
    test_sra();
    test_sll_ror();
    test_zero_shamt();
    test_backpressure();
    test_reset_mid();
    fork
      test_exhaustive(1);
      test_exhaustive(2);
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
